// File: rtl/dmem_bus_arbiter.sv
// dmem_bus_arbiter: shares one data-memory/MMIO slave port between two bus masters
//
// M0 is the core data port, M1 the UART loader/DMA. One transaction runs at a time:
// IDLE -> ISSUE -> (WAIT_RD) -> IDLE. A write completes in its issue cycle. A read
// waits for s_read_valid_i and is aborted with an error after TIMEOUT_CYCLES wait cycles.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   mX_req_i/we_i/addr_i/
//   wdata_i/wmask_i            master request, held until mX_done_o
//   mX_gnt_o                   master owns the slave (registered)
//   mX_done_o/err_o/rdata_o    registered completion pulse, timeout flag, read data
//   s_*_o / s_read_*_i         slave port
//
// Configuration
//   ARB_ROUND_ROBIN_EN  defined: simultaneous requests go to the master not granted last.
//                       undefined: fixed priority, M0 beats M1.
module dmem_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_wdata_i,
    input  logic [3:0]  m0_wmask_i,
    output logic        m0_gnt_o,
    output logic        m0_done_o,
    output logic        m0_err_o,
    output logic [31:0] m0_rdata_o,
    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_wdata_i,
    input  logic [3:0]  m1_wmask_i,
    output logic        m1_gnt_o,
    output logic        m1_done_o,
    output logic        m1_err_o,
    output logic [31:0] m1_rdata_o,
    output logic [31:0] s_address_o,
    output logic [31:0] s_write_data_o,
    output logic [3:0]  s_write_mask_o,
    output logic        s_write_enable_o,
    output logic        s_read_enable_o,
    input  logic [31:0] s_read_data_i,
    input  logic        s_read_valid_i
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
    state_t      state_q, state_d;
    logic [1:0]  gnt_q, gnt_d, done_q, done_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        last_q, last_d, err_q, err_d, fin;
    logic [31:0] rdata_q, rdata_d;
    logic        sel, busy, cur_we, pick_m1;
    assign sel    = gnt_q[1];
    assign busy   = state_q != IDLE;
    assign cur_we = sel ? m1_we_i : m0_we_i;
`ifdef ARB_ROUND_ROBIN_EN
    // on contention hand the slave to whoever did not finish last
    assign pick_m1 = m1_req_i & (~m0_req_i | ~last_q);
`else
    assign pick_m1 = m1_req_i & ~m0_req_i;
`endif
    assign s_address_o    = busy ? (sel ? m1_addr_i  : m0_addr_i)  : '0;
    assign s_write_data_o = busy ? (sel ? m1_wdata_i : m0_wdata_i) : '0;
    assign s_write_mask_o = busy ? (sel ? m1_wmask_i : m0_wmask_i) : '0;
    assign m0_gnt_o   = gnt_q[0];
    assign m1_gnt_o   = gnt_q[1];
    assign m0_done_o  = done_q[0];
    assign m1_done_o  = done_q[1];
    assign m0_err_o   = done_q[0] & err_q;
    assign m1_err_o   = done_q[1] & err_q;
    assign m0_rdata_o = done_q[0] ? rdata_q : '0;
    assign m1_rdata_o = done_q[1] ? rdata_q : '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            rdata_q <= rdata_d;
        end
    end
    always_comb begin
        state_d          = state_q;
        gnt_d            = gnt_q;
        cnt_d            = cnt_q;
        last_d           = last_q;
        done_d           = '0;
        err_d            = 1'b0;
        rdata_d          = '0;
        fin              = 1'b0;
        s_write_enable_o = 1'b0;
        s_read_enable_o  = 1'b0;
        case (state_q)
            // the cycle after a done pulse is skipped so the finished master can drop req
            IDLE: if ((m0_req_i | m1_req_i) && done_q == 2'b00) begin
                gnt_d   = pick_m1 ? 2'b10 : 2'b01;
                state_d = ISSUE;
            end
            ISSUE: begin
                s_write_enable_o = cur_we;
                s_read_enable_o  = ~cur_we;
                cnt_d            = '0;
                fin              = cur_we;
                state_d          = cur_we ? IDLE : WAIT_RD;
            end
            WAIT_RD: begin
                s_read_enable_o = 1'b1;
                cnt_d           = cnt_q + 8'd1;
                rdata_d         = s_read_valid_i ? s_read_data_i : '0;
                fin             = s_read_valid_i | (cnt_q == TO_LAST);
                state_d         = fin ? IDLE : WAIT_RD;
            end
            default: state_d = IDLE;
        endcase
        if (fin) begin
            done_d = gnt_q;
            err_d  = (state_q == WAIT_RD) & ~s_read_valid_i;
            gnt_d  = '0;
            last_d = sel;
        end
    end
endmodule

// File: tb/tb_dmem_bus_arbiter.sv
// tb_dmem_bus_arbiter: directed self-checking bench for dmem_bus_arbiter (TIMEOUT_CYCLES=8)
module tb_dmem_bus_arbiter;
    logic        clk = 1'b0, rst;
    logic        m0_req, m0_we, m0_gnt, m0_done, m0_err;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic [3:0]  m0_wmask;
    logic        m1_req, m1_we, m1_gnt, m1_done, m1_err;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m1_wmask;
    logic [31:0] s_address, s_write_data, s_read_data;
    logic [3:0]  s_write_mask;
    logic        s_we, s_re, s_valid;
    int          passed = 0, total = 0;
    dmem_bus_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
        .m0_wmask_i(m0_wmask), .m0_gnt_o(m0_gnt), .m0_done_o(m0_done), .m0_err_o(m0_err),
        .m0_rdata_o(m0_rdata),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
        .m1_wmask_i(m1_wmask), .m1_gnt_o(m1_gnt), .m1_done_o(m1_done), .m1_err_o(m1_err),
        .m1_rdata_o(m1_rdata),
        .s_address_o(s_address), .s_write_data_o(s_write_data), .s_write_mask_o(s_write_mask),
        .s_write_enable_o(s_we), .s_read_enable_o(s_re),
        .s_read_data_i(s_read_data), .s_read_valid_i(s_valid)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask
    task automatic tick;
        @(negedge clk);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
    initial begin
        int n_re, lat, g, cyc, last_cyc;
        logic prev;
        logic [3:0] who;
        rst = 1'b1;
        {m0_req, m0_we, m0_addr, m0_wdata, m0_wmask} = '0;
        {m1_req, m1_we, m1_addr, m1_wdata, m1_wmask} = '0;
        {s_read_data, s_valid} = '0;
        repeat (3) tick;
        rst = 1'b0;
        tick;
        chk("rst_gnt", 32'({m0_gnt, m1_gnt}), 32'd0);
        chk("rst_done_err", 32'({m0_done, m1_done, m0_err, m1_err}), 32'd0);
        chk("rst_strobes", 32'({s_we, s_re}), 32'd0);
        chk("rst_addr", s_address, 32'd0);
        // M0 write
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h40; m0_wdata = 32'hDEADBEEF; m0_wmask = 4'hF;
        tick;
        chk("wr_gnt", 32'(m0_gnt), 32'd1);
        chk("wr_swe", 32'(s_we), 32'd1);
        chk("wr_addr", s_address, 32'h40);
        chk("wr_wdata", s_write_data, 32'hDEADBEEF);
        chk("wr_wmask", 32'(s_write_mask), 32'hF);
        chk("wr_done_early", 32'(m0_done), 32'd0);
        tick;
        chk("wr_done", 32'(m0_done), 32'd1);
        chk("wr_err", 32'(m0_err), 32'd0);
        chk("wr_swe_one_cycle", 32'(s_we), 32'd0);
        chk("wr_gnt_cleared", 32'(m0_gnt), 32'd0);
        chk("wr_m1_quiet", 32'({m1_done, m1_err, m1_gnt}), 32'd0);
        chk("wr_m1_rdata", m1_rdata, 32'd0);
        m0_req = 1'b0; m0_we = 1'b0;
        tick;
        chk("wr_done_pulse", 32'(m0_done), 32'd0);
        // M1 read, slave answers in the third wait cycle
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h80; s_read_data = 32'h12345678;
        n_re = 0;
        for (int i = 0; i < 4; i++) begin
            tick;
            n_re += int'(s_re);
            if (i == 0) chk("rd_addr", s_address, 32'h80);
            if (i == 3) s_valid = 1'b1;
        end
        tick;
        chk("rd_done", 32'(m1_done), 32'd1);
        chk("rd_rdata", m1_rdata, 32'h12345678);
        chk("rd_err", 32'(m1_err), 32'd0);
        chk("rd_re_cycles", 32'(n_re), 32'd4);
        chk("rd_re_off", 32'(s_re), 32'd0);
        chk("rd_m0_quiet", 32'(m0_done), 32'd0);
        m1_req = 1'b0;
        tick;
        s_valid = 1'b0;
        tick;
        chk("idle_valid_ignored", 32'({m0_done, m1_done, s_re}), 32'd0);
        // contention: both masters keep requesting writes
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h0;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h4;
        g = 0; cyc = 0; last_cyc = 0; prev = 1'b0; who = '0;
        while (g < 4 && cyc < 60) begin
            tick;
            cyc++;
            if ((m0_gnt | m1_gnt) && !prev) begin
                who[g] = m1_gnt;
                chk("ct_addr", s_address, m1_gnt ? 32'h4 : 32'h0);
                if (g > 0) chk("ct_gap", 32'(cyc - last_cyc), 32'd3);
                last_cyc = cyc;
                g++;
            end
            prev = m0_gnt | m1_gnt;
        end
        chk("ct_grants", 32'(g), 32'd4);
`ifdef ARB_ROUND_ROBIN_EN
        chk("ct_order", 32'(who), 32'b1010);
`else
        chk("ct_order", 32'(who), 32'b0000);
`endif
        tick;
        m0_req = 1'b0;
        for (int i = 0; i < 10 && !(m0_gnt | m1_gnt); i++) tick;
        chk("ct_m1_after_drop", 32'({m0_gnt, m1_gnt}), 32'b01);
        tick;
        chk("ct_m1_done", 32'(m1_done), 32'd1);
        m1_req = 1'b0; m0_we = 1'b0; m1_we = 1'b0;
        tick;
        // M0 read timeout
        m0_req = 1'b1; m0_addr = 32'h10; s_read_data = 32'hAAAA5555;
        n_re = 0; lat = 0;
        for (int i = 0; i < 30 && !m0_done; i++) begin
            tick;
            lat++;
            n_re += int'(s_re);
        end
        chk("to_done", 32'(m0_done), 32'd1);
        chk("to_err", 32'(m0_err), 32'd1);
        chk("to_rdata", m0_rdata, 32'd0);
        chk("to_latency", 32'(lat), 32'd10);
        chk("to_re_cycles", 32'(n_re), 32'd9);
        chk("to_gnt_cleared", 32'(m0_gnt), 32'd0);
        m0_req = 1'b0;
        tick;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h8;
        tick;
        tick;
        chk("to_next_served", 32'({m1_done, m1_err}), 32'b10);
        m1_req = 1'b0;
        tick;
        // valid arrives in the same cycle as the timeout
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h20; s_read_data = 32'hCAFEF00D;
        n_re = 0;
        for (int i = 0; i < 30 && !m0_done; i++) begin
            tick;
            n_re += int'(s_re);
            if (n_re == 9) s_valid = 1'b1;
        end
        chk("vt_done", 32'(m0_done), 32'd1);
        chk("vt_err", 32'(m0_err), 32'd0);
        chk("vt_rdata", m0_rdata, 32'hCAFEF00D);
        s_valid = 1'b0; m0_req = 1'b0;
        tick;
        // reset while waiting for read data
        m0_req = 1'b1; m0_addr = 32'h30;
        tick;
        tick;
        chk("rw_in_wait", 32'(s_re), 32'd1);
        rst = 1'b1;
        tick;
        chk("rw_gnt", 32'({m0_gnt, m1_gnt}), 32'd0);
        chk("rw_strobes", 32'({s_we, s_re}), 32'd0);
        chk("rw_no_done", 32'(m0_done), 32'd0);
        rst = 1'b0; m0_req = 1'b0;
        tick;
        chk("rw_no_late_done", 32'(m0_done), 32'd0);
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h44; m0_wdata = 32'h0BADF00D;
        tick;
        chk("rw_write_addr", s_address, 32'h44);
        tick;
        chk("rw_write_done", 32'({m0_done, m0_err}), 32'b10);
        m0_req = 1'b0;
        tick;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
